fetch_unit: RTL and testbench

- Upstream stage of the control unit. Owns the 16-bit program counter, the instruction register (opcode_reg) and a one-byte operand register.
- Out of reset it runs the 6502 reset-vector sequence, then drives the PC onto the address bus and latches fetched bytes under control-unit strobes.
- Supplies opcode (the live bus byte) and opcode_reg (the latched byte) to the control unit.

---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: loads the PC from the reset vector, then puts the PC on the address bus
// and latches instruction/operand bytes when the control unit strobes.
module fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [7:0]  NOP_OPCODE   = 8'hEA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        instruction_load,
  input  logic        increment_pc,
  input  logic        operand_load,
  input  logic        address_select,
  output logic [15:0] address,
  output logic [7:0]  opcode,
  output logic [7:0]  opcode_reg,
  output logic [7:0]  operand_reg,
  output logic [15:0] pc,
  output logic        running
);

  typedef enum logic [1:0] {
    VEC_LO = 2'b00,
    VEC_HI = 2'b01,
    RUN    = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  opcode_reg_q, opcode_reg_d;
  logic [7:0]  operand_reg_q, operand_reg_d;
  logic        running_q, running_d;

  // Next-state, register updates and the combinational bus outputs
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    opcode_reg_d  = opcode_reg_q;
    operand_reg_d = operand_reg_q;
    address       = RESET_VECTOR;
    opcode        = NOP_OPCODE;
    case (state_q)
      VEC_HI: begin
        address = RESET_VECTOR + 16'd1;
        pc_d    = {data_in, pc_q[7:0]};
        state_d = RUN;
      end
      RUN: begin
        opcode = data_in;
        if (address_select) begin
          address = {8'h00, operand_reg_q};
        end else begin
          address = pc_q;
        end
        if (instruction_load) begin
          opcode_reg_d = data_in;
        end else begin
          opcode_reg_d = opcode_reg_q;
        end
        if (operand_load) begin
          operand_reg_d = data_in;
        end else begin
          operand_reg_d = operand_reg_q;
        end
        if (increment_pc) begin
          pc_d = pc_q + 16'd1;
        end else begin
          pc_d = pc_q;
        end
      end
      // VEC_LO, plus the unused encoding so a corrupted state restarts the vector fetch
      default: begin
        address = RESET_VECTOR;
        pc_d    = {pc_q[15:8], data_in};
        state_d = VEC_HI;
      end
    endcase
    running_d = (state_d == RUN);
  end

  // State and datapath registers; reset overrides every strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= VEC_LO;
      pc_q          <= 16'h0000;
      opcode_reg_q  <= NOP_OPCODE;
      operand_reg_q <= 8'h00;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      opcode_reg_q  <= opcode_reg_d;
      operand_reg_q <= operand_reg_d;
      running_q     <= running_d;
    end
  end

  assign pc          = pc_q;
  assign opcode_reg  = opcode_reg_q;
  assign operand_reg = operand_reg_q;
  assign running     = running_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with an asynchronous-read 64 KiB memory model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in;
  logic        instruction_load;
  logic        increment_pc;
  logic        operand_load;
  logic        address_select;
  logic [15:0] address;
  logic [7:0]  opcode;
  logic [7:0]  opcode_reg;
  logic [7:0]  operand_reg;
  logic [15:0] pc;
  logic        running;

  logic [7:0] mem [0:65535];
  int total;
  int passed;

  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .data_in          (data_in),
    .instruction_load (instruction_load),
    .increment_pc     (increment_pc),
    .operand_load     (operand_load),
    .address_select   (address_select),
    .address          (address),
    .opcode           (opcode),
    .opcode_reg       (opcode_reg),
    .operand_reg      (operand_reg),
    .pc               (pc),
    .running          (running)
  );

  assign data_in = mem[address];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mem[16'hFFFC] = 8'h34;
    mem[16'hFFFD] = 8'h12;
    reset = 1'b1;
    tick();
    tick();
    total++; if (running !== 1'b0) $display("FAIL rst_running: got %b want 0", running); else passed++;
    total++; if (pc !== 16'h0000) $display("FAIL rst_pc: got %h want 0000", pc); else passed++;
    total++; if (opcode_reg !== 8'hEA) $display("FAIL rst_opcode_reg: got %h want ea", opcode_reg); else passed++;
    total++; if (operand_reg !== 8'h00) $display("FAIL rst_operand_reg: got %h want 00", operand_reg); else passed++;
    total++; if (opcode !== 8'hEA) $display("FAIL rst_opcode: got %h want ea", opcode); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_vector_fetch();
    #1;
    total++; if (address !== 16'hFFFC) $display("FAIL vec_addr_lo: got %h want fffc", address); else passed++;
    tick();
    total++; if (address !== 16'hFFFD) $display("FAIL vec_addr_hi: got %h want fffd", address); else passed++;
    total++; if (pc !== 16'h0034) $display("FAIL vec_pc_lo: got %h want 0034", pc); else passed++;
    total++; if (opcode !== 8'hEA) $display("FAIL vec_opcode_nop: got %h want ea", opcode); else passed++;
    total++; if (running !== 1'b0) $display("FAIL vec_running_early: got %b want 0", running); else passed++;
    tick();
    total++; if (running !== 1'b1) $display("FAIL vec_running: got %b want 1", running); else passed++;
    total++; if (pc !== 16'h1234) $display("FAIL vec_pc: got %h want 1234", pc); else passed++;
    total++; if (address !== 16'h1234) $display("FAIL vec_addr_run: got %h want 1234", address); else passed++;
  endtask

  task automatic test_fetch_increment();
    mem[16'h1234] = 8'h69;
    mem[16'h1235] = 8'h80;
    #1;
    total++; if (opcode !== 8'h69) $display("FAIL fetch_opcode_live: got %h want 69", opcode); else passed++;
    instruction_load = 1'b1;
    increment_pc = 1'b1;
    tick();
    instruction_load = 1'b0;
    increment_pc = 1'b0;
    total++; if (opcode_reg !== 8'h69) $display("FAIL fetch_opcode_reg: got %h want 69", opcode_reg); else passed++;
    total++; if (pc !== 16'h1235) $display("FAIL fetch_pc: got %h want 1235", pc); else passed++;
    total++; if (opcode !== 8'h80) $display("FAIL fetch_opcode_next: got %h want 80", opcode); else passed++;
  endtask

  task automatic test_operand_indirect();
    mem[16'h0080] = 8'h5A;
    operand_load = 1'b1;
    increment_pc = 1'b1;
    tick();
    operand_load = 1'b0;
    increment_pc = 1'b0;
    address_select = 1'b1;
    #1;
    total++; if (operand_reg !== 8'h80) $display("FAIL opnd_reg: got %h want 80", operand_reg); else passed++;
    total++; if (pc !== 16'h1236) $display("FAIL opnd_pc: got %h want 1236", pc); else passed++;
    total++; if (address !== 16'h0080) $display("FAIL opnd_addr: got %h want 0080", address); else passed++;
    total++; if (opcode !== 8'h5A) $display("FAIL opnd_opcode: got %h want 5a", opcode); else passed++;
    address_select = 1'b0;
    tick();
    total++; if (pc !== 16'h1236) $display("FAIL hold_pc: got %h want 1236", pc); else passed++;
    total++; if (opcode_reg !== 8'h69) $display("FAIL hold_opcode_reg: got %h want 69", opcode_reg); else passed++;
    total++; if (operand_reg !== 8'h80) $display("FAIL hold_operand_reg: got %h want 80", operand_reg); else passed++;
  endtask

  task automatic test_dual_load();
    mem[16'h1236] = 8'hC3;
    instruction_load = 1'b1;
    operand_load = 1'b1;
    tick();
    instruction_load = 1'b0;
    operand_load = 1'b0;
    total++; if (opcode_reg !== 8'hC3) $display("FAIL dual_opcode_reg: got %h want c3", opcode_reg); else passed++;
    total++; if (operand_reg !== 8'hC3) $display("FAIL dual_operand_reg: got %h want c3", operand_reg); else passed++;
    total++; if (pc !== 16'h1236) $display("FAIL dual_pc: got %h want 1236", pc); else passed++;
  endtask

  task automatic test_mid_reset();
    instruction_load = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    instruction_load = 1'b0;
    total++; if (opcode_reg !== 8'hEA) $display("FAIL midrst_opcode_reg: got %h want ea", opcode_reg); else passed++;
    total++; if (running !== 1'b0) $display("FAIL midrst_running: got %b want 0", running); else passed++;
    total++; if (address !== 16'hFFFC) $display("FAIL midrst_addr: got %h want fffc", address); else passed++;
    total++; if (operand_reg !== 8'h00) $display("FAIL midrst_operand_reg: got %h want 00", operand_reg); else passed++;
    tick();
    total++; if (address !== 16'hFFFD) $display("FAIL midrst_addr_hi: got %h want fffd", address); else passed++;
    tick();
    total++; if (running !== 1'b1) $display("FAIL midrst_running_again: got %b want 1", running); else passed++;
    total++; if (pc !== 16'h1234) $display("FAIL midrst_pc: got %h want 1234", pc); else passed++;
  endtask

  task automatic test_strobes_during_vector();
    mem[16'hFFFC] = 8'hFF;
    mem[16'hFFFD] = 8'hFF;
    instruction_load = 1'b1;
    increment_pc = 1'b1;
    operand_load = 1'b1;
    address_select = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (address !== 16'hFFFC) $display("FAIL strb_addr_lo: got %h want fffc", address); else passed++;
    tick();
    total++; if (address !== 16'hFFFD) $display("FAIL strb_addr_hi: got %h want fffd", address); else passed++;
    total++; if (opcode !== 8'hEA) $display("FAIL strb_opcode: got %h want ea", opcode); else passed++;
    tick();
    instruction_load = 1'b0;
    increment_pc = 1'b0;
    operand_load = 1'b0;
    address_select = 1'b0;
    total++; if (opcode_reg !== 8'hEA) $display("FAIL strb_opcode_reg: got %h want ea", opcode_reg); else passed++;
    total++; if (operand_reg !== 8'h00) $display("FAIL strb_operand_reg: got %h want 00", operand_reg); else passed++;
    total++; if (pc !== 16'hFFFF) $display("FAIL strb_pc: got %h want ffff", pc); else passed++;
    total++; if (running !== 1'b1) $display("FAIL strb_running: got %b want 1", running); else passed++;
  endtask

  task automatic test_wrap();
    mem[16'h0000] = 8'h11;
    increment_pc = 1'b1;
    tick();
    increment_pc = 1'b0;
    total++; if (pc !== 16'h0000) $display("FAIL wrap_pc: got %h want 0000", pc); else passed++;
    total++; if (running !== 1'b1) $display("FAIL wrap_running: got %b want 1", running); else passed++;
    total++; if (opcode !== 8'h11) $display("FAIL wrap_opcode: got %h want 11", opcode); else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset = 1'b1;
    instruction_load = 1'b0;
    increment_pc = 1'b0;
    operand_load = 1'b0;
    address_select = 1'b0;
    test_reset();
    test_vector_fetch();
    test_fetch_increment();
    test_operand_indirect();
    test_dual_load();
    test_mid_reset();
    test_strobes_during_vector();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
